// File: rtl/branch_seq_ctrl_pkg.sv
// Shared constants, encodings and helpers for the branch resolution controller.
package branch_seq_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I conditional-branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } ctrlState_t;

  // 010 and 011 are not branch encodings
  function automatic logic isIllegal(input logic [2:0] funct3);
    return (funct3 == 3'b010) || (funct3 == 3'b011);
  endfunction

  // funct3[1] clear selects the signed compare
  function automatic logic isSigned(input logic [2:0] funct3);
    return ~funct3[1];
  endfunction

  // Branch decision from the combined compare flags
  function automatic logic branchTaken(input logic [2:0] funct3, input logic eq, input logic lt);
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = eq;
      F3_BNE:           taken = ~eq;
      F3_BLT, F3_BLTU:  taken = lt;
      F3_BGE, F3_BGEU:  taken = ~lt;
      default:          taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_seq_ctrl_slice_comp.sv
// Combinational unsigned magnitude comparator for one operand slice.
module branch_seq_ctrl_slice_comp #(
  parameter int unsigned SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               eq_c,
  output logic               lt_c
);

  // Equality and unsigned less-than of the slice pair
  always_comb begin
    eq_c = (a == b);
    lt_c = (a < b);
  end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Multi-cycle branch resolution controller sharing one slice comparator, MS slice first.
module branch_seq_ctrl
  import branch_seq_ctrl_pkg::*;
#(
  parameter int unsigned SLICE_W    = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_taken,
  output logic [XLEN-1:0] resp_next_pc,
  output logic            resp_eq,
  output logic            resp_lt,
  output logic            resp_misalign,
  output logic            resp_illegal,
  output logic            busy
);

  localparam int unsigned NSLICE = XLEN / SLICE_W;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  ctrlState_t      state;
  logic [KW-1:0]   kIdx;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] target;
  logic [2:0]      funct3Q;
  logic            decided;
  logic            ltQ;

  logic sliceEq;
  logic sliceLt;
  logic lastSlice;
  logic finalEq;
  logic finalLt;
  logic cmpDone;
  logic takenC;
  logic [XLEN-1:0] signMask;

  // Operands are shifted left each step, so the active slice is always the top bits
  branch_seq_ctrl_slice_comp #(.SLICE_W(SLICE_W)) uSliceComp (
    .a    (opA[XLEN-1 -: SLICE_W]),
    .b    (opB[XLEN-1 -: SLICE_W]),
    .eq_c (sliceEq),
    .lt_c (sliceLt)
  );

  // Handshake and status decode from the state register
  assign req_ready  = (state == IDLE) & ~flush & ~rst;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // Fold the current slice into the running result; first unequal slice decides
  always_comb begin
    signMask  = {isSigned(req_funct3), {(XLEN-1){1'b0}}};
    lastSlice = (kIdx == KW'(NSLICE - 1));
    finalEq   = ~decided & sliceEq;
    finalLt   = decided ? ltQ : (~sliceEq & sliceLt);
    cmpDone   = lastSlice | (EARLY_EXIT & ~decided & ~sliceEq);
    takenC    = branchTaken(funct3Q, finalEq, finalLt);
  end

  // FSM, slice walk and registered response fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      kIdx          <= '0;
      opA           <= '0;
      opB           <= '0;
      pcPlus4       <= '0;
      target        <= '0;
      funct3Q       <= '0;
      decided       <= 1'b0;
      ltQ           <= 1'b0;
      resp_taken    <= 1'b0;
      resp_next_pc  <= '0;
      resp_eq       <= 1'b0;
      resp_lt       <= 1'b0;
      resp_misalign <= 1'b0;
      resp_illegal  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            funct3Q <= req_funct3;
            pcPlus4 <= req_pc + XLEN'(4);
            target  <= req_pc + req_imm;
            opA     <= req_rs1 ^ signMask;
            opB     <= req_rs2 ^ signMask;
            kIdx    <= '0;
            decided <= 1'b0;
            ltQ     <= 1'b0;
            if (isIllegal(req_funct3)) begin
              state         <= RESP;
              resp_taken    <= 1'b0;
              resp_next_pc  <= req_pc + XLEN'(4);
              resp_eq       <= 1'b0;
              resp_lt       <= 1'b0;
              resp_misalign <= 1'b0;
              resp_illegal  <= 1'b1;
            end else begin
              state <= CMP;
            end
          end
        end
        CMP: begin
          if (!decided && !sliceEq) begin
            decided <= 1'b1;
            ltQ     <= sliceLt;
          end
          if (cmpDone) begin
            state         <= RESP;
            resp_taken    <= takenC;
            resp_next_pc  <= takenC ? target : pcPlus4;
            resp_eq       <= finalEq;
            resp_lt       <= finalLt;
            resp_misalign <= takenC & (|target[1:0]);
            resp_illegal  <= 1'b0;
          end else begin
            kIdx <= kIdx + KW'(1);
            opA  <= opA << SLICE_W;
            opB  <= opB << SLICE_W;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
